// File: rtl/escritor_rtc_if.sv
// Bus between the user-control requester and the RTC write sequencer.
// estado mirrors the sequencer FSM state for checkers and debug.
interface escritor_rtc_if;
    logic       solicitud;
    logic       concedido;
    logic       escritura;
    logic [7:0] direccion;
    logic [7:0] dato;
    logic       final_req;
    logic       fin;
    logic [7:0] AD;
    logic       AD_oe;
    logic       CS_n;
    logic       RD_n;
    logic       WR_n;
    logic       AD_sel;
    logic       ocupado;
    logic [3:0] estado;

    // Handshake: the requester holds solicitud for the whole session and
    // escritura while a write is pending; a write is accepted on the edge
    // where the sequencer is in GRANT with escritura=1, and completes with a
    // one-clock fin pulse. final_req=1 seen in GRANT ends the session.
    modport master (
        output solicitud, escritura, direccion, dato, final_req,
        input  concedido, fin, AD, AD_oe, CS_n, RD_n, WR_n, AD_sel, ocupado, estado
    );
    modport slave (
        input  solicitud, escritura, direccion, dato, final_req,
        output concedido, fin, AD, AD_oe, CS_n, RD_n, WR_n, AD_sel, ocupado, estado
    );
endinterface

// File: rtl/escritor_rtc.sv
// RTC write sequencer: multiplexed address/data write cycle, each bus phase TPH clocks.
// All outputs are registered from the next-state decode.
module escritor_rtc #(
    parameter int unsigned TPH = 4
) (
    input  logic           CLK,
    input  logic           reset,
    escritor_rtc_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, GRANT, A_SET, A_WR, A_HOLD, D_SET, D_WR, D_HOLD, FIN, GAP
    } state_t;

    localparam logic [3:0] C_PHASE_LOAD = 4'(TPH - 1);
    localparam logic [3:0] C_GAP_LOAD   = 4'd1;

    state_t     r_state, w_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic [7:0] r_dir, r_dat, w_dir_next, w_dat_next;
    logic       r_abort, w_abort_next;
    logic       w_done;

    logic       r_concedido, r_fin, r_ad_oe, r_cs_n, r_wr_n, r_ad_sel, r_ocupado;
    logic [7:0] r_ad;
    logic       w_concedido, w_fin, w_ad_oe, w_cs_n, w_wr_n, w_ad_sel, w_ocupado;
    logic [7:0] w_ad;

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir;
        w_dat_next   = r_dat;
        w_abort_next = r_abort;
        w_done       = (r_cnt == 4'd0);

        case (r_state)
            IDLE:   if (bus.solicitud) w_next = GRANT;
            GRANT: begin
                if (bus.final_req || !bus.solicitud) begin
                    w_next = IDLE;
                end else if (bus.escritura) begin
                    w_next       = A_SET;
                    w_dir_next   = bus.direccion;
                    w_dat_next   = bus.dato;
                    w_abort_next = 1'b0;
                end
            end
            A_SET:  if (w_done) w_next = A_WR;
            A_WR:   if (w_done) w_next = A_HOLD;
            A_HOLD: if (w_done) w_next = D_SET;
            D_SET:  if (w_done) w_next = D_WR;
            D_WR:   if (w_done) w_next = D_HOLD;
            D_HOLD: if (w_done) w_next = (r_abort || !bus.solicitud) ? IDLE : FIN;
            FIN:    w_next = GAP;
            GAP:    if (w_done) w_next = GRANT;
            default: w_next = IDLE;
        endcase

        // A dropped request inside the bus cycle is remembered so the cycle
        // finishes intact but ends silently in IDLE.
        if (r_state inside {A_SET, A_WR, A_HOLD, D_SET, D_WR, D_HOLD} && !bus.solicitud)
            w_abort_next = 1'b1;

        if (w_next != r_state)
            w_cnt_next = (w_next == GAP) ? C_GAP_LOAD : C_PHASE_LOAD;
        else if (!w_done)
            w_cnt_next = r_cnt - 4'd1;

        w_concedido = (w_next != IDLE);
        w_ocupado   = (w_next != IDLE);
        w_fin       = (w_next == FIN);
        w_ad_oe     = w_next inside {A_SET, A_WR, A_HOLD, D_SET, D_WR, D_HOLD};
        w_ad_sel    = w_next inside {D_SET, D_WR, D_HOLD};
        w_cs_n      = !(w_next inside {A_SET, A_WR, D_SET, D_WR});
        w_wr_n      = !(w_next inside {A_WR, D_WR});
        w_ad        = 8'h00;
        if (w_next inside {A_SET, A_WR, A_HOLD})
            w_ad = w_dir_next;
        else if (w_next inside {D_SET, D_WR, D_HOLD})
            w_ad = w_dat_next;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_dir       <= 8'h00;
            r_dat       <= 8'h00;
            r_abort     <= 1'b0;
            r_concedido <= 1'b0;
            r_fin       <= 1'b0;
            r_ad        <= 8'h00;
            r_ad_oe     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_ad_sel    <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_dir       <= w_dir_next;
            r_dat       <= w_dat_next;
            r_abort     <= w_abort_next;
            r_concedido <= w_concedido;
            r_fin       <= w_fin;
            r_ad        <= w_ad;
            r_ad_oe     <= w_ad_oe;
            r_cs_n      <= w_cs_n;
            r_wr_n      <= w_wr_n;
            r_ad_sel    <= w_ad_sel;
            r_ocupado   <= w_ocupado;
        end
    end

    assign bus.concedido = r_concedido;
    assign bus.fin       = r_fin;
    assign bus.AD        = r_ad;
    assign bus.AD_oe     = r_ad_oe;
    assign bus.CS_n      = r_cs_n;
    assign bus.RD_n      = 1'b1;
    assign bus.WR_n      = r_wr_n;
    assign bus.AD_sel    = r_ad_sel;
    assign bus.ocupado   = r_ocupado;
    assign bus.estado    = r_state;
endmodule

// File: doc/escritor_rtc.md
ESCRITOR_RTC -- requirements
Module: escritor_rtc

Interface
REQ-001 Parameter: TPH, default 4, clocks per bus phase; legal range 1..15.
REQ-002 Ports: CLK  in  1  system clock; all logic on rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high; sampled on rising CLK.
REQ-004 Ports: solicitud  in  1  bus request from the user-control block (its Maquina_out).
REQ-005 Ports: concedido  out  1  bus grant to the user-control block (its Maquina_in).
REQ-006 Ports: escritura  in  1  write pending; held high by requester, not pulsed.
REQ-007 Ports: direccion  in  8  RTC register address (0x21-0x26 time/date, 0x41-0x43 alarm, 0x00 status).
REQ-008 Ports: dato  in  8  byte to write.
REQ-009 Ports: final  in  1  requester's end-of-sequence flag.
REQ-010 Ports: fin  out  1  one-cycle pulse: current write completed.
REQ-011 Ports: AD  out  8  multiplexed RTC address/data bus value.
REQ-012 Ports: AD_oe  out  1  bus driver enable, 1 = drive AD.
REQ-013 Ports: CS_n, RD_n, WR_n, AD_sel  out  1 each  RTC strobes; AD_sel 0 = address phase, 1 = data phase.
REQ-014 Ports: ocupado  out  1  high whenever state is not IDLE.

Function
REQ-015 States SHALL be IDLE, GRANT, A_SET, A_WR, A_HOLD, D_SET, D_WR, D_HOLD, FIN, GAP; each bus phase state (A_SET..D_HOLD) SHALL last exactly TPH clocks, timed by a 4-bit counter reloaded on every state entry.
REQ-016 IDLE: concedido=0; on solicitud=1 -> GRANT.
REQ-017 GRANT: concedido=1; if final=1 or solicitud=0 -> IDLE; else if escritura=1 -> A_SET, latching direccion and dato into internal registers on that edge.
REQ-018 A_SET: AD_oe=1, AD=latched address, AD_sel=0, CS_n=0, WR_n=1.
REQ-019 A_WR: as A_SET but WR_n=0.
REQ-020 A_HOLD: WR_n=1, CS_n=1, AD held; then D_SET.
REQ-021 D_SET/D_WR/D_HOLD: identical to address phases with AD=latched data, AD_sel=1.
REQ-022 RD_n SHALL be 1 at all times; AD_oe SHALL be 0 in IDLE, GRANT, FIN, GAP.
REQ-023 FIN: fin=1 for exactly one clock, then GAP.
REQ-024 GAP: 2 clocks, fin=0, escritura ignored (requester updates address/data during this time); then GRANT.
REQ-025 Latched address/data SHALL not change between A_SET entry and FIN, regardless of input activity.
REQ-026 solicitud falling during A_SET..D_HOLD: bus cycle SHALL complete unmodified; fin suppressed; D_HOLD -> IDLE directly.
REQ-027 final=1 observed in GRANT SHALL win over escritura=1 on the same edge (no further write).
REQ-028 Back-to-back writes: minimum spacing fin-to-fin = 6*TPH + 4 clocks.
REQ-029 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-030 On reset=1: state=IDLE, counter=0, concedido=0, fin=0, AD=0x00, AD_oe=0, CS_n=1, RD_n=1, WR_n=1, AD_sel=0, ocupado=0, latches=0x00.
REQ-031 Reset asserted mid-cycle SHALL abort immediately; strobes return to inactive on the next edge, no fin.

Verification
REQ-032 TPH=4, solicitud=1, escritura=1, direccion=0x21, dato=0x59 -> concedido next clock; AD=0x21 with AD_sel=0, WR_n low 4 clocks; then AD=0x59 with AD_sel=1, WR_n low 4 clocks; single fin pulse 24 clocks after A_SET entry.
REQ-033 Sequence of 10 writes (0x21..0x26, 0x41..0x43, 0x00), final=1 after 10th fin -> exactly 10 fin pulses, concedido drops 1 clock after final seen in GRANT, ocupado=0.
REQ-034 direccion/dato changed during D_WR -> AD still shows originally latched values through D_HOLD.
REQ-035 solicitud dropped in A_WR -> cycle completes to D_HOLD, fin stays 0, state IDLE, concedido=0.
REQ-036 reset pulsed in D_WR -> next clock CS_n=1, WR_n=1, AD_oe=0, AD=0x00, fin=0; later request restarts cleanly.
REQ-037 TPH=1: full write cycle A_SET..D_HOLD = 6 clocks, fin spacing 10 clocks with escritura held high.
